// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: digit patterns (active-low,
// seg[0]=a .. seg[6]=g), blank/dash patterns and counter sizing.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIV_W      = 16;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decode; codes A..F show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit common-anode display scanner with per-frame snapshot and one
// blank cycle per digit slot. Optional leading-zero blanking: SEG7_LZB_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 12_500
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_en,
  input  logic [4*NUM_DIGITS-1:0]   i_bcd_in,
  input  logic [NUM_DIGITS-1:0]     i_dp_in,
  output logic [6:0]                o_seg,
  output logic                      o_dp,
  output logic [NUM_DIGITS-1:0]     o_an,
  output logic                      o_frame_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0]          r_div;
  logic [1:0]                r_idx;
  logic [4*NUM_DIGITS-1:0]   r_snap;
  logic [NUM_DIGITS-1:0]     r_dpSnap;
  logic [6:0]                r_seg;
  logic                      r_dp;
  logic [NUM_DIGITS-1:0]     r_an;
  logic                      r_frameTick;

  logic                      w_divZero;
  logic                      w_divWrap;
  logic                      w_snapLoad;
  logic [3:0]                w_digit;
  logic [6:0]                w_segPat;
  logic                      w_lzBlank;

  assign w_divZero  = (r_div == '0);
  assign w_divWrap  = (r_div == DIV_LAST);
  assign w_snapLoad = i_en && w_divZero && (r_idx == 2'd0);
  assign w_digit    = r_snap[{r_idx, 2'b00} +: 4];

  bcd_to_seg7 u_decode (
    .i_bcd (w_digit),
    .o_seg (w_segPat)
  );

`ifdef SEG7_LZB_EN
  // A digit goes dark only if it and every digit above it are zero.
  always_comb begin
    w_lzBlank = 1'b0;
    case (r_idx)
      2'd3:    w_lzBlank = (r_snap[15:12] == 4'd0) && !r_dpSnap[3];
      2'd2:    w_lzBlank = (r_snap[15:8]  == 8'd0) && !r_dpSnap[2];
      2'd1:    w_lzBlank = (r_snap[15:4]  == 12'd0) && !r_dpSnap[1];
      default: w_lzBlank = 1'b0;
    endcase
  end
`else
  assign w_lzBlank = 1'b0;
`endif

  // Registers update on the falling edge to line up with the upstream timer.
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      r_div       <= '0;
      r_idx       <= 2'd0;
      r_snap      <= '0;
      r_dpSnap    <= '0;
      r_an        <= '1;
      r_seg       <= SEG_BLANK;
      r_dp        <= 1'b1;
      r_frameTick <= 1'b0;
    end else begin
      r_frameTick <= w_snapLoad;
      if (w_snapLoad) begin
        r_snap   <= i_bcd_in;
        r_dpSnap <= i_dp_in;
      end
      if (i_en) begin
        if (w_divWrap) begin
          r_div <= '0;
          r_idx <= r_idx + 2'd1;
        end else begin
          r_div <= r_div + DIV_ONE;
        end
      end
      if (!i_en || w_divZero || w_lzBlank) begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= w_segPat;
        r_dp  <= ~r_dpSnap[r_idx];
      end
    end
  end

  assign o_an         = r_an;
  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_frame_tick = r_frameTick;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan (DIGIT_CYCLES=4) with a reference-model
// scoreboard plus literal spot checks of the expected scan pattern.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] bcd;
  logic [3:0]  dpIn;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        tick;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  exp_t        expQ[$];
  int          mDiv;
  int          mIdx;
  logic [15:0] mSnap;
  logic [3:0]  mDpSnap;
  int          nChecks = 0;
  int          nPassed = 0;

  always #5 clk = ~clk;

  seg7_scan #(.DIGIT_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_en         (en),
    .i_bcd_in     (bcd),
    .i_dp_in      (dpIn),
    .o_seg        (seg),
    .o_dp         (dp),
    .o_an         (an),
    .o_frame_tick (tick)
  );

  function automatic logic [6:0] refDecode(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic refLzb(input int idx, input logic [15:0] s, input logic [3:0] d);
    if (idx == 0 || d[idx]) return 1'b0;
    for (int j = idx; j < 4; j++)
      if (s[j*4 +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    nChecks++;
    assert (obs === expv) nPassed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Pops the expectation pushed for the edge that just happened.
  task automatic checkOutput();
    exp_t x;
    if (expQ.size() == 0) begin
      checkVal("queueEmpty", 16'd1, 16'd0);
      return;
    end
    x = expQ.pop_front();
    checkVal("an",   {12'd0, an},  {12'd0, x.an});
    checkVal("seg",  {9'd0, seg},  {9'd0, x.seg});
    checkVal("dp",   {15'd0, dp},  {15'd0, x.dp});
    checkVal("tick", {15'd0, tick}, {15'd0, x.tick});
  endtask

  // Drives one cycle of inputs, predicts the next falling edge, then checks.
  task automatic applyStimulus(input logic r, input logic e, input logic [15:0] b, input logic [3:0] d);
    exp_t       x;
    logic       load;
    logic       lz;
    logic [3:0] anExp;
    @(posedge clk);
    rst  = r;
    en   = e;
    bcd  = b;
    dpIn = d;
    if (r) begin
      x = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
      mDiv = 0; mIdx = 0; mSnap = '0; mDpSnap = '0;
    end else begin
      load = e && (mDiv == 0) && (mIdx == 0);
      lz = 1'b0;
`ifdef SEG7_LZB_EN
      lz = refLzb(mIdx, mSnap, mDpSnap);
`endif
      x.tick = load;
      if (!e || mDiv == 0 || lz) begin
        x.an = 4'hF; x.seg = 7'h7F; x.dp = 1'b1;
      end else begin
        anExp = 4'hF;
        anExp[mIdx] = 1'b0;
        x.an  = anExp;
        x.seg = refDecode(mSnap[mIdx*4 +: 4]);
        x.dp  = ~mDpSnap[mIdx];
      end
      if (load) begin
        mSnap = b; mDpSnap = d;
      end
      if (e) begin
        if (mDiv == 3) begin
          mDiv = 0;
          mIdx = (mIdx + 1) % 4;
        end else begin
          mDiv = mDiv + 1;
        end
      end
    end
    expQ.push_back(x);
    @(negedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic seenUpper;
    rst = 1'b1; en = 1'b1; bcd = '0; dpIn = '0;
    mDiv = 0; mIdx = 0; mSnap = '0; mDpSnap = '0;
    $display("[TB] seg7_scan bench start");

    repeat (3) begin
      applyStimulus(1'b1, 1'b1, 16'h1234, 4'h0);
      checkVal("rstAn", {12'd0, an}, 16'h000F);
    end

    for (int k = 1; k <= 34; k++) begin
      applyStimulus(1'b0, 1'b1, 16'h1234, 4'h0);
      if (k == 1)  checkVal("firstTick", {15'd0, tick}, 16'd1);
      if (k == 2)  checkVal("dig0An", {12'd0, an}, 16'h000E);
      if (k == 2)  checkVal("dig0Seg", {9'd0, seg}, 16'h0019);
      if (k == 6)  checkVal("dig1Seg", {9'd0, seg}, 16'h0030);
      if (k == 16) checkVal("noTick16", {15'd0, tick}, 16'd0);
      if (k == 17) checkVal("tick17", {15'd0, tick}, 16'd1);
    end

    applyStimulus(1'b1, 1'b1, 16'h0000, 4'h0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 1'b1, (k < 7) ? 16'h1234 : 16'h5678, 4'h0);
      if (k == 11) checkVal("tearDig2", {9'd0, seg}, 16'h0024);
      if (k == 14) checkVal("tearDig3", {9'd0, seg}, 16'h0079);
      if (k == 19) checkVal("newDig0", {9'd0, seg}, 16'h0000);
    end

    applyStimulus(1'b1, 1'b1, 16'h0000, 4'h0);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 1'b1, 16'h000A, 4'b0001);
      if (k == 2) checkVal("dashSeg", {9'd0, seg}, 16'h003F);
      if (k == 2) checkVal("dpOn", {15'd0, dp}, 16'd0);
      if (k == 6) checkVal("dpOff", {15'd0, dp}, 16'd1);
    end

    applyStimulus(1'b1, 1'b1, 16'h0000, 4'h0);
    for (int k = 1; k <= 6; k++) applyStimulus(1'b0, 1'b1, 16'h1234, 4'h0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h1234, 4'h0);
      checkVal("enOffAn", {12'd0, an}, 16'h000F);
    end
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b1, 16'h1234, 4'h0);
      if (k == 1) checkVal("resumeAn", {12'd0, an}, 16'h000D);
      if (k == 3) checkVal("resumeBlank", {12'd0, an}, 16'h000F);
      if (k == 4) checkVal("resumeDig2", {12'd0, an}, 16'h000B);
    end

    applyStimulus(1'b1, 1'b1, 16'h0000, 4'h0);
    seenUpper = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(1'b0, 1'b1, 16'h0009, 4'h0);
      if (an[3:1] != 3'b111) seenUpper = 1'b1;
      if (k == 2) checkVal("nineSeg", {9'd0, seg}, 16'h0010);
`ifndef SEG7_LZB_EN
      if (k == 6) checkVal("zeroDig1", {9'd0, seg}, 16'h0040);
`endif
    end
`ifdef SEG7_LZB_EN
    checkVal("lzbUpperDark", {15'd0, seenUpper}, 16'd0);
`else
    checkVal("upperLit", {15'd0, seenUpper}, 16'd1);
`endif

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
